// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined-mode RAM responder with a fixed response latency and
// an optional stall window after each accepted request.
module wb_ram_slave #(
    parameter int ADDR_WIDTH   = 12,
    parameter int LATENCY      = 1,
    parameter int STALL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o
);

    localparam int MEM_WORDS = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [MEM_WORDS];
    logic [31:0]           rd_q;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic [2:0]            stall_cnt;
    logic [LATENCY-1:0]    ack_sr;
    logic [LATENCY-1:0]    err_sr;
    logic                  rd_head;
    logic [31:0]           head_dat;
    logic                  unused_adr_lsb;

    // Byte address below MEM_BYTES <=> every bit above the word index is zero.
    assign word_idx       = wb_adr_i[ADDR_WIDTH+1:2];
    assign in_range       = (wb_adr_i[31:ADDR_WIDTH+2] == '0);
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    assign wb_stall_o = (stall_cnt != 3'd0);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

    // NOTE: the RAM array has no reset; only control state is reset, so the
    // array can map onto block RAM and keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            if (wb_we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel_i[b]) begin
                        mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                    end
                end
            end
            rd_q <= mem[word_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage of
    // the shift register samples the value from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sr    <= '0;
            err_sr    <= '0;
            rd_head   <= 1'b0;
            stall_cnt <= 3'd0;
        end else if (!wb_cyc_i) begin
            ack_sr    <= '0;
            err_sr    <= '0;
            rd_head   <= 1'b0;
            stall_cnt <= 3'd0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                ack_sr[i] <= ack_sr[i-1];
                err_sr[i] <= err_sr[i-1];
            end
            ack_sr[0] <= accept & in_range;
            err_sr[0] <= accept & ~in_range;
            rd_head   <= accept & in_range & ~wb_we_i;
            if (accept) begin
                stall_cnt <= 3'(STALL_CYCLES);
            end else if (stall_cnt != 3'd0) begin
                stall_cnt <= stall_cnt - 3'd1;
            end
        end
    end

    // Read data is only non-zero in the stage that carries an in-range read ack.
    assign head_dat = rd_head ? rd_q : 32'd0;

    generate
        if (LATENCY == 1) begin : g_direct
            assign wb_dat_o = head_dat;
        end else begin : g_pipe
            logic [31:0] dat_sr [1:LATENCY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i < LATENCY; i++) dat_sr[i] <= 32'd0;
                end else if (!wb_cyc_i) begin
                    for (int i = 1; i < LATENCY; i++) dat_sr[i] <= 32'd0;
                end else begin
                    dat_sr[1] <= head_dat;
                    for (int i = LATENCY - 1; i > 1; i--) dat_sr[i] <= dat_sr[i-1];
                end
            end

            assign wb_dat_o = dat_sr[LATENCY-1];
        end
    endgenerate

    assign wb_ack_o = ack_sr[LATENCY-1];
    assign wb_err_o = err_sr[LATENCY-1];

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone B4 pipelined-mode responder: single-port word-organised RAM with configurable read/write response latency and stall insertion.
- The far end of the Wishbone links that the Ibex core wrapper drives for instruction and data traffic through its core-to-Wishbone bridges.
- Serves as on-chip instruction/data memory in SoC tops.
- Serves as a latency/stall-programmable target for verifying the master-side bridges.

Parameters:
- ADDR_WIDTH, 12: word-address bits. Memory holds 2**ADDR_WIDTH 32-bit words, i.e. MEM_BYTES = 4*2**ADDR_WIDTH.
- LATENCY, 1: cycles from accept to ack/err. Legal range 1..4.
- STALL_CYCLES, 0: stall cycles inserted after every accepted request. Legal range 0..7.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- wb_cyc_i, input, 1: bus cycle valid.
- wb_stb_i, input, 1: request strobe.
- wb_we_i, input, 1: 1 = write, 0 = read.
- wb_sel_i, input, 4: byte lane select, bit n = bits 8n+7:8n.
- wb_adr_i, input, 32: byte address. Bits 1:0 are ignored.
- wb_dat_i, input, 32: write data.
- wb_dat_o, output, 32: read data, valid with wb_ack_o.
- wb_ack_o, output, 1: normal termination, one cycle per request.
- wb_err_o, output, 1: error termination, one cycle per request.
- wb_stall_o, output, 1: request not accepted this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: wb_ack_o=0, wb_err_o=0, wb_stall_o=0, wb_dat_o=0, response pipeline empty, stall counter 0. RAM contents are not reset.
- Accept: accept = wb_cyc_i & wb_stb_i & ~wb_stall_o. Exactly one request is accepted per accept cycle.
- Range check: in_range = (wb_adr_i < MEM_BYTES). Word index = wb_adr_i[ADDR_WIDTH+1:2].
- Accepted write, in range: at the accept clock edge, each byte lane with wb_sel_i=1 is written; the other lanes are kept. sel=0 is legal, writes nothing and is still acked.
- Accepted read, in range: the RAM word is sampled at the accept edge. A read accepted the cycle after a write to the same word returns the new data.
- Out-of-range request: no RAM write; response is err, not ack; wb_dat_o=0.
- Response pipeline: LATENCY-stage shift register of {ack, err, data}. The response for an accept in cycle T appears on the outputs in cycle T+LATENCY, for exactly one cycle.
- Response ordering: responses come back in request order. Back-to-back accepts give back-to-back responses.
- Response outputs: wb_ack_o and wb_err_o are never high together.
- wb_dat_o: equals the read data only while wb_ack_o is high on a read; it is 0 in every other cycle, including write acks.
- Stall: a counter is loaded with STALL_CYCLES on each accept and decrements to 0. wb_stall_o = (counter != 0). With STALL_CYCLES=0, wb_stall_o is constantly 0 and one request per cycle is sustained.
- stb without cyc: ignored; no accept and the stall counter is not loaded.
- Cycle abort: wb_cyc_i low in any cycle clears all in-flight pipeline entries and the stall counter at that edge. No ack/err is emitted for aborted requests, and the outputs are already 0 in the cycle after cyc falls. Writes committed at earlier accept edges stay committed.
- Reset mid-operation: all pipeline entries and the stall counter are cleared asynchronously. Outputs go to their reset values immediately; RAM is unaffected.
- Outstanding requests: no limit beyond LATENCY. The pipeline depth equals LATENCY, so no overflow is possible.

Test Plan:
- Basic write/read (LATENCY=1, STALL_CYCLES=0): write 0xDEADBEEF to 0x10 with sel=0xF → ack in the next cycle, dat_o=0. Read 0x10 → ack next cycle with dat_o=0xDEADBEEF.
- Byte lanes: with 0xDEADBEEF at 0x10, write 0x0000AA00 with sel=4'b0010 → ack. Reading 0x10 then returns 0xDEADAAEF. A write with sel=0 leaves the word unchanged and is still acked.
- Pipelined burst (LATENCY=2): preload 0x0,0x4,0x8,0xC with 1,2,3,4, then issue 4 back-to-back reads accepted in cycles 0..3 → acks in cycles 2..5 carrying 1,2,3,4 in order, with no stall.
- Out of range (ADDR_WIDTH=12): write 0xFFFFFFFF to 0x4000 → err (not ack) after LATENCY, dat_o=0. Then read 0x4000 → err. Read 0x0 → ack, contents unchanged.
- Stall insertion (STALL_CYCLES=2): hold stb high for 3 requests → accepts in cycles 0,3,6, stall high in cycles 1-2 and 4-5, and 3 acks in total.
- Abort and reset (LATENCY=3): accept 2 reads, then drop cyc for 1 cycle → no ack/err appears. A new cycle's read acks normally. Asserting rst_n=0 with a request in flight clears ack/err/stall immediately.
